neuron_accumulator: RTL and testbench
=====================================

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 33, giving the number of product terms per neuron (32 weighted inputs plus 1 bias term).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the width of each signed two's-complement product and of the result.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 40, giving the internal accumulator width, which SHALL be at least WIDTH+ceil(log2(N_TERMS)).
REQ-004 The block SHALL have parameter RELU, default 1: 1 applies ReLU after saturation; 0 bypasses it.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  product vector valid.
- in_ready  output  1  block can accept a vector.
- products  input  [N_TERMS-1:0][WIDTH-1:0]  signed products from the upstream multiplier stage; index N_TERMS-1 is the bias term.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  activated neuron output.
- out_sat  output  1  pre-activation sum was clipped.

Function
REQ-006 The block SHALL implement a state machine with three states: IDLE, ACCUM and DONE.
REQ-007 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-008 out_valid SHALL be 1 exactly when the state is DONE.
REQ-009 An input handshake (in_valid & in_ready at a rising edge) SHALL register all of products into an internal buffer, clear the accumulator to 0, clear the index to 0, and move the state to ACCUM.
REQ-010 In ACCUM, each edge SHALL add the sign-extended buffer[index] to the accumulator and increment the index.
REQ-011 The edge that adds index N_TERMS-1 SHALL move the state to DONE and register out_data and out_sat from the final sum.
REQ-012 Latency SHALL therefore be exactly N_TERMS edges (33 by default) from the input handshake edge to out_valid=1.
REQ-013 products SHALL be ignored outside the input handshake edge; changing them during ACCUM SHALL NOT affect the result.
REQ-014 Saturation: a sum greater than 2^(WIDTH-1)-1 SHALL clip to 0x7FFFFFFF; a sum less than -2^(WIDTH-1) SHALL clip to 0x80000000; out_sat SHALL be 1 when clipping occurs and 0 otherwise.
REQ-015 With RELU=1, a negative saturated value SHALL become 0; out_sat SHALL still report any negative clipping.
REQ-016 With RELU=0, the saturated value SHALL pass through unchanged.
REQ-017 The accumulator SHALL NOT overflow internally for any input; with the default widths the maximum magnitude is 33*2^31 < 2^39.
REQ-018 In DONE, out_data and out_sat SHALL hold stable until the output handshake (out_valid & out_ready).
REQ-019 The output handshake SHALL return the state to IDLE.
REQ-020 in_ready SHALL be 0 during the output handshake cycle, so no same-cycle re-accept occurs.
REQ-021 The minimum throughput SHALL be one vector per N_TERMS+2 cycles.
REQ-022 in_valid asserted during ACCUM or DONE SHALL be ignored (backpressure); the upstream stage SHALL hold it until in_ready.
REQ-023 out_ready asserted in IDLE or ACCUM SHALL have no effect.

Reset
REQ-024 Asserting rst_n=0 at any time, including mid-ACCUM or in DONE, SHALL immediately set the state to IDLE.
REQ-025 During reset, in_ready SHALL be 1, out_valid 0, out_data 0, out_sat 0, and the accumulator and index 0.
REQ-026 A partially accumulated vector SHALL be discarded on reset and never output.
REQ-027 After rst_n deasserts, the first input handshake SHALL be possible at the first rising edge.

Verification
REQ-028 The bench SHALL cover: all 33 products = 1, RELU=1 -> out_valid rises exactly 33 edges after accept; out_data=33; out_sat=0.
REQ-029 The bench SHALL cover: products[0..31] = -5, bias = 100 -> sum -60; RELU=1 gives out_data=0, out_sat=0; RELU=0 gives out_data=0xFFFFFFC4.
REQ-030 The bench SHALL cover: all products = 0x7FFFFFFF -> out_data=0x7FFFFFFF, out_sat=1; all products = 0x80000000 with RELU=0 -> out_data=0x80000000, out_sat=1.
REQ-031 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_data stable and in_ready=0 throughout; products changed at edge 5 of ACCUM -> result unchanged.
REQ-032 The bench SHALL cover: rst_n pulsed low at accumulate edge 17 -> out_valid never rises for that vector; in_ready=1 immediately; the next vector is accepted and produces the correct sum.
REQ-033 The bench SHALL cover: in_valid held high continuously with out_ready=1 -> two back-to-back vectors are accepted exactly 35 cycles apart.

Source files
------------

// File: rtl/neuron_accumulator.sv
// -----------------------------------------------------------------------------
// neuron_accumulator
//
// Sequential multiply-accumulate back end for one neuron. A vector of N_TERMS
// signed products (the last one being the bias) is captured in a single input
// handshake. The products are then summed one term per clock into a wide
// accumulator. The final sum is saturated to WIDTH bits, optionally passed
// through ReLU, and presented on a valid/ready output port.
//
// Parameters
//   N_TERMS   : product terms per neuron (weighted inputs + 1 bias)
//   WIDTH     : width of each signed product and of the result
//   ACC_WIDTH : accumulator width, must be >= WIDTH + ceil(log2(N_TERMS))
//   RELU      : 1 = clamp negative results to zero, 0 = linear output
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : product vector valid
//   in_ready  : block can accept a vector (state IDLE)
//   products  : signed products, index N_TERMS-1 is the bias term
//   out_valid : result valid (state DONE)
//   out_ready : downstream accepts the result
//   out_data  : activated neuron output
//   out_sat   : pre-activation sum was clipped
// -----------------------------------------------------------------------------
module neuron_accumulator #(
    parameter int N_TERMS   = 33,
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int RELU      = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_TERMS-1:0][WIDTH-1:0]   products,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_sat
);

    localparam int IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    // Saturation bounds expressed at accumulator width so the compare is
    // a plain signed comparison against the full-precision sum.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                          state_q,    state_d;
    logic [N_TERMS-1:0][WIDTH-1:0]   buffer_q,   buffer_d;
    logic signed [ACC_WIDTH-1:0]     acc_q,      acc_d;
    logic [IDX_W-1:0]                idx_q,      idx_d;
    logic [WIDTH-1:0]                out_data_q, out_data_d;
    logic                            out_sat_q,  out_sat_d;

    logic signed [ACC_WIDTH-1:0]     term_s;
    logic signed [ACC_WIDTH-1:0]     sum_s;
    logic [WIDTH-1:0]                sat_value_s;
    logic                            sat_flag_s;
    logic [WIDTH-1:0]                act_value_s;
    logic                            last_term_s;

    // Datapath: sign-extend the current buffered term, add it, then clip and activate.
    always_comb begin
        term_s      = {{(ACC_WIDTH-WIDTH){buffer_q[idx_q][WIDTH-1]}}, buffer_q[idx_q]};
        sum_s       = acc_q + term_s;
        last_term_s = (idx_q == IDX_W'(N_TERMS-1));

        if (sum_s > SAT_MAX) begin
            sat_value_s = {1'b0, {(WIDTH-1){1'b1}}};
            sat_flag_s  = 1'b1;
        end else if (sum_s < SAT_MIN) begin
            sat_value_s = {1'b1, {(WIDTH-1){1'b0}}};
            sat_flag_s  = 1'b1;
        end else begin
            sat_value_s = sum_s[WIDTH-1:0];
            sat_flag_s  = 1'b0;
        end

        // ReLU acts on the already-clipped value; out_sat still reports a
        // negative clip even though the output then reads zero.
        if ((RELU != 0) && sat_value_s[WIDTH-1]) begin
            act_value_s = {WIDTH{1'b0}};
        end else begin
            act_value_s = sat_value_s;
        end
    end

    // Next-state and register-update logic for the IDLE/ACCUM/DONE machine.
    always_comb begin
        state_d    = state_q;
        buffer_d   = buffer_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        case (state_q)
            IDLE: begin
                // in_ready is high in IDLE, so in_valid alone completes the handshake.
                if (in_valid) begin
                    buffer_d = products;
                    acc_d    = {ACC_WIDTH{1'b0}};
                    idx_d    = {IDX_W{1'b0}};
                    state_d  = ACCUM;
                end else begin
                    state_d  = IDLE;
                end
            end
            ACCUM: begin
                acc_d = sum_s;
                idx_d = idx_q + IDX_W'(1'b1);
                if (last_term_s) begin
                    out_data_d = act_value_s;
                    out_sat_d  = sat_flag_s;
                    state_d    = DONE;
                end else begin
                    state_d    = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partially summed vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buffer_q   <= {(N_TERMS*WIDTH){1'b0}};
            acc_q      <= {ACC_WIDTH{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            out_data_q <= {WIDTH{1'b0}};
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buffer_q   <= buffer_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Handshake outputs decode straight from the state register; data is registered.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = out_data_q;
        out_sat   = out_sat_q;
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// -----------------------------------------------------------------------------
// tb_neuron_accumulator
//
// Directed bench for neuron_accumulator. Two instances share all inputs: one
// with ReLU enabled and one linear. Expected results come from a 64-bit
// reference sum, are queued when a vector is accepted, and are popped when
// out_valid is seen.
// -----------------------------------------------------------------------------
module tb_neuron_accumulator;

    localparam int NT = 33;

    typedef struct {
        logic [31:0] d_relu;
        logic [31:0] d_lin;
        logic        sat;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 out_ready;
    logic [NT-1:0][31:0]  products;
    logic                 in_ready_r,  in_ready_l;
    logic                 out_valid_r, out_valid_l;
    logic [31:0]          out_data_r,  out_data_l;
    logic                 out_sat_r,   out_sat_l;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t held;

    neuron_accumulator #(.N_TERMS(NT), .WIDTH(32), .ACC_WIDTH(40), .RELU(1)) u_dut_relu (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .products(products), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_sat(out_sat_r)
    );

    neuron_accumulator #(.N_TERMS(NT), .WIDTH(32), .ACC_WIDTH(40), .RELU(0)) u_dut_lin (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
        .products(products), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .out_sat(out_sat_l)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: exact 64-bit sum, clip to 32 bits, then ReLU.
    function automatic exp_t model(input logic [NT-1:0][31:0] p);
        exp_t   e;
        longint s;
        longint maxv;
        longint minv;
        maxv = 64'sh0000_0000_7FFF_FFFF;
        minv = -64'sh0000_0000_8000_0000;
        s = 64'sd0;
        for (int i = 0; i < NT; i++) begin
            s += longint'($signed(p[i]));
        end
        if (s > maxv) begin
            e.d_lin = 32'h7FFF_FFFF;
            e.sat   = 1'b1;
        end else if (s < minv) begin
            e.d_lin = 32'h8000_0000;
            e.sat   = 1'b1;
        end else begin
            e.d_lin = s[31:0];
            e.sat   = 1'b0;
        end
        e.d_relu = e.d_lin[31] ? 32'h0000_0000 : e.d_lin;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, queue the expectation and complete one accept edge.
    task automatic do_accept();
        int n;
        n = 0;
        while (!in_ready_r && n < 50) begin
            step();
            n++;
        end
        check("accept_ready", in_ready_r, 1'b1);
        sb.push_back(model(products));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Pop one expectation and compare both instances' outputs against it.
    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            held = e;
            check({tag, "_valid_lin"}, out_valid_l, 1'b1);
            check({tag, "_data_relu"}, out_data_r, e.d_relu);
            check({tag, "_data_lin"},  out_data_l, e.d_lin);
            check({tag, "_sat_relu"},  out_sat_r,  e.sat);
            check({tag, "_sat_lin"},   out_sat_l,  e.sat);
        end
    endtask

    // Count edges since accept until out_valid (bounded), then check latency and data.
    task automatic wait_done(input string tag, input int start);
        int n;
        n = start;
        while (!out_valid_r && n < 60) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 32'd33);
        compare_out(tag);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, in_ready_r, 1'b1);
        check({tag, "_idle_valid"}, out_valid_r, 1'b0);
    endtask

    initial begin
        int acc_cyc[2];
        int n_acc;
        int n_out;
        int cyc;
        logic accepting;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NT; i++) products[i] = 32'h0000_0000;

        // Reset values
        step();
        step();
        check("rst_in_ready_r",  in_ready_r,  1'b1);
        check("rst_in_ready_l",  in_ready_l,  1'b1);
        check("rst_out_valid",   out_valid_r, 1'b0);
        check("rst_out_data_r",  out_data_r,  32'h0000_0000);
        check("rst_out_data_l",  out_data_l,  32'h0000_0000);
        check("rst_out_sat",     out_sat_r,   1'b0);
        rst_n = 1'b1;

        // All ones -> 33, accepted at the first edge after reset release
        for (int i = 0; i < NT; i++) products[i] = 32'h0000_0001;
        do_accept();
        wait_done("ones", 0);
        release_out("ones");

        // -5 x 32 plus bias 100 -> -60
        for (int i = 0; i < NT-1; i++) products[i] = 32'hFFFF_FFFB;
        products[NT-1] = 32'h0000_0064;
        do_accept();
        wait_done("neg60", 0);
        release_out("neg60");

        // Positive saturation
        for (int i = 0; i < NT; i++) products[i] = 32'h7FFF_FFFF;
        do_accept();
        wait_done("satpos", 0);
        release_out("satpos");

        // Negative saturation
        for (int i = 0; i < NT; i++) products[i] = 32'h8000_0000;
        do_accept();
        wait_done("satneg", 0);
        release_out("satneg");

        // Products changed mid-ACCUM, in_valid/out_ready toggled in ACCUM, then DONE hold
        for (int i = 0; i < NT; i++) products[i] = $urandom_range(32'd2000, 32'd0) - 32'd1000;
        do_accept();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 5) begin
                for (int i = 0; i < NT; i++) products[i] = 32'h7FFF_FFFF;
            end
            if (e == 30) begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
        end
        check("hold_accum_valid", out_valid_r, 1'b0);
        wait_done("hold", 32);
        for (int k = 0; k < 10; k++) begin
            step();
            check("hold_data_relu", out_data_r, held.d_relu);
            check("hold_data_lin",  out_data_l, held.d_lin);
            check("hold_in_ready",  in_ready_r, 1'b0);
            check("hold_out_valid", out_valid_r, 1'b1);
        end
        release_out("hold");

        // Reset at accumulate edge 17 discards the vector
        for (int i = 0; i < NT; i++) products[i] = 32'(i);
        do_accept();
        for (int e = 1; e <= 17; e++) step();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  in_ready_r,  1'b1);
        check("midrst_out_valid", out_valid_r, 1'b0);
        check("midrst_out_data",  out_data_l,  32'h0000_0000);
        check("midrst_out_sat",   out_sat_l,   1'b0);
        #1;
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < NT-1; i++) products[i] = 32'h0000_0002;
        products[NT-1] = 32'hFFFF_FFFF;
        do_accept();
        wait_done("postrst", 0);
        release_out("postrst");

        // Back-to-back: in_valid and out_ready held high
        for (int i = 0; i < NT; i++) products[i] = 32'h0000_0003;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n_acc = 0;
        n_out = 0;
        cyc   = 0;
        for (int e = 0; e < 120 && n_out < 2; e++) begin
            accepting = in_ready_r && in_valid;
            if (accepting) sb.push_back(model(products));
            step();
            cyc++;
            if (accepting) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                for (int i = 0; i < NT; i++) products[i] = 32'(i) - 32'd20;
                if (n_acc == 2) in_valid = 1'b0;
            end
            if (out_valid_r) begin
                compare_out("b2b");
                n_out++;
            end
        end
        check("b2b_outputs", n_out, 32'd2);
        check("b2b_accepts", n_acc, 32'd2);
        if (n_acc == 2) begin
            check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 32'd35);
        end
        step();
        out_ready = 1'b0;
        check("b2b_end_ready", in_ready_r, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
